// File: rtl/cdm16_int_ctrl.sv
// Programmable interrupt controller for the cdm16 core: edge/level capture, masking,
// nested priority selection, vector hand-off on iack and EOI-driven in-service tracking.
module cdm16_int_ctrl #(
  parameter int unsigned N_SRC    = 8,
  parameter logic [5:0]  VEC_BASE = 6'd16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  output logic             irq,
  output logic [5:0]       int_vec,
  input  logic             iack,
  input  logic [2:0]       reg_addr,
  input  logic             reg_wr,
  input  logic [15:0]      reg_wdata,
  output logic [15:0]      reg_rdata
);

  localparam int unsigned IDX_W = 4;

  if (N_SRC < 1 || N_SRC > 16 || (int'(VEC_BASE) + int'(N_SRC) - 1) > 63) begin : g_bad_param
    $error("cdm16_int_ctrl: N_SRC must be 1..16 and VEC_BASE+N_SRC-1 must not exceed 63");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2
  } state_t;

  state_t             r_state;
  logic [N_SRC-1:0]   r_mask;
  logic [N_SRC-1:0]   r_edge;
  logic [N_SRC-1:0]   r_pending;
  logic [N_SRC-1:0]   r_inserv;
  logic [N_SRC-1:0]   r_src_q;
  logic               r_iack_q;
  logic               r_irq;
  logic [5:0]         r_int_vec;
  logic [IDX_W-1:0]   r_cur_idx;

  logic [N_SRC-1:0]   w_wdata_n;
  logic               w_wr_mask;
  logic               w_wr_edge;
  logic               w_wr_pend;
  logic               w_wr_eoi;
  logic [N_SRC-1:0]   w_ins_low;
  logic [N_SRC-1:0]   w_below;
  logic [N_SRC-1:0]   w_elig;
  logic [N_SRC-1:0]   w_cur_oh;
  logic               w_cur_elig;
  logic               w_any;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_ack;
  logic [N_SRC-1:0]   w_rise;
  logic [N_SRC-1:0]   w_w1c;
  logic [N_SRC-1:0]   w_ack_clr;
  logic [N_SRC-1:0]   w_pend_edge;
  logic [N_SRC-1:0]   w_pend_next;
  logic [N_SRC-1:0]   w_inserv_next;

  if (N_SRC < 16) begin : g_wdata_hi
    logic w_unused_wdata_hi;
    assign w_unused_wdata_hi = ^reg_wdata[15:N_SRC];
  end

  assign w_wdata_n = reg_wdata[N_SRC-1:0];
  assign w_wr_mask = reg_wr && (reg_addr == 3'd0);
  assign w_wr_edge = reg_wr && (reg_addr == 3'd1);
  assign w_wr_pend = reg_wr && (reg_addr == 3'd2);
  assign w_wr_eoi  = reg_wr && (reg_addr == 3'd4);

  // Isolate lowest in-service bit; minus one yields the "strictly higher priority" window
  // (all ones when nothing is in service).
  assign w_ins_low = r_inserv & (~r_inserv + N_SRC'(1));
  assign w_below   = w_ins_low - N_SRC'(1);
  assign w_elig    = r_pending & r_mask & w_below;

  assign w_cur_oh   = N_SRC'(1) << r_cur_idx;
  assign w_cur_elig = |(w_elig & w_cur_oh);

  // Lowest eligible index wins.
  always_comb begin
    w_any     = 1'b0;
    w_win_idx = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any     = 1'b1;
        w_win_idx = IDX_W'(i);
      end
    end
  end

  assign w_ack     = (r_state == S_REQ) && iack && !r_iack_q;
  assign w_rise    = src & ~r_src_q;
  assign w_w1c     = w_wr_pend ? w_wdata_n : '0;
  assign w_ack_clr = w_ack ? w_cur_oh : '0;

  // A fresh rising edge wins over both W1C and the ack clear.
  assign w_pend_edge   = (r_pending & ~w_w1c & ~w_ack_clr) | w_rise;
  assign w_pend_next   = (r_edge & w_pend_edge) | (~r_edge & src);
  assign w_inserv_next = (r_inserv & ~(w_wr_eoi ? w_ins_low : '0)) | (w_ack ? w_cur_oh : '0);

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0:    reg_rdata = 16'(r_mask);
      3'd1:    reg_rdata = 16'(r_edge);
      3'd2:    reg_rdata = 16'(r_pending);
      3'd3:    reg_rdata = 16'(r_inserv);
      3'd5:    reg_rdata = 16'({r_state, r_irq, r_cur_idx});
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_edge    <= '0;
      r_pending <= '0;
      r_inserv  <= '0;
      r_src_q   <= '0;
      r_iack_q  <= 1'b0;
      r_irq     <= 1'b0;
      r_int_vec <= '0;
      r_cur_idx <= '0;
    end else begin
      r_src_q   <= src;
      r_iack_q  <= iack;
      r_pending <= w_pend_next;
      r_inserv  <= w_inserv_next;
      if (w_wr_mask) r_mask <= w_wdata_n;
      if (w_wr_edge) r_edge <= w_wdata_n;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cur_idx <= w_win_idx;
            r_int_vec <= VEC_BASE + 6'(w_win_idx);
            r_irq     <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            r_irq   <= 1'b0;
            r_state <= S_ACKED;
          end else if (w_any && (w_win_idx < r_cur_idx)) begin
            r_cur_idx <= w_win_idx;
            r_int_vec <= VEC_BASE + 6'(w_win_idx);
          end else if (!w_cur_elig) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ACKED: begin
          if (!iack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq     = r_irq;
  assign int_vec = r_int_vec;

endmodule
